// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_pkg
//  Description : Shared types and constants for the fetch PC generator:
//                address type, FSM state encodings, BTB counter values,
//                boolean constants and the saturating-counter helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_gen_pkg;

    localparam int ADDR_W_DEF = 32;

    typedef logic [ADDR_W_DEF-1:0] AddrType;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_BUBBLE = 2'd2
    } state_e;

    localparam logic [1:0] CTR_STRONG_NT = 2'b00;
    localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
    localparam logic [1:0] CTR_WEAK_T    = 2'b10;
    localparam logic [1:0] CTR_STRONG_T  = 2'b11;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Two-bit saturating counter step toward the resolved outcome.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_STRONG_T) res = ctr + 2'd1;
        end else begin
            if (ctr != CTR_STRONG_NT) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_if
//  Description : Bundle of the fetch handshake, ROB redirect and BTB training
//                signals around the PC generator. The master modport is the
//                PC generator itself; the slave modport is its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_gen_if #(
    parameter int ADDR_W = 32
) ();
    logic              rdy;
    logic              stall_in;
    logic              fetch_valid_out;
    logic              fetch_ready_in;
    logic [ADDR_W-1:0] fetch_pc_out;
    logic              fetch_pred_taken_out;
    logic [ADDR_W-1:0] fetch_pred_target_out;
    logic              flush_sig_in;
    logic [ADDR_W-1:0] flush_pc_in;
    logic              btb_upd_sig_in;
    logic [ADDR_W-1:0] btb_upd_pc_in;
    logic [ADDR_W-1:0] btb_upd_target_in;
    logic              btb_upd_taken_in;

    modport master (
        input  rdy, stall_in, fetch_ready_in,
        input  flush_sig_in, flush_pc_in,
        input  btb_upd_sig_in, btb_upd_pc_in, btb_upd_target_in, btb_upd_taken_in,
        output fetch_valid_out, fetch_pc_out, fetch_pred_taken_out, fetch_pred_target_out
    );

    modport slave (
        output rdy, stall_in, fetch_ready_in,
        output flush_sig_in, flush_pc_in,
        output btb_upd_sig_in, btb_upd_pc_in, btb_upd_target_in, btb_upd_taken_in,
        input  fetch_valid_out, fetch_pc_out, fetch_pred_taken_out, fetch_pred_target_out
    );
endinterface
`default_nettype wire

// File: rtl/pc_gen_btb.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen_btb
//  Description : Direct-mapped branch target buffer with 2-bit saturating
//                counters. Combinational lookup port, synchronous training
//                port. PCs arrive word-aligned (bits [1:0] already stripped).
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_gen_btb
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BTB_ENTRIES = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              en_i,
    input  wire logic [ADDR_W-3:0] lkp_word_i,
    output logic                   lkp_hit_o,
    output logic [ADDR_W-1:0]      lkp_target_o,
    input  wire logic              upd_sig_i,
    input  wire logic [ADDR_W-3:0] upd_word_i,
    input  wire logic [ADDR_W-1:0] upd_target_i,
    input  wire logic              upd_taken_i
);

    localparam int IDX_W  = $clog2(BTB_ENTRIES);
    localparam int WORD_W = ADDR_W - 2;
    localparam int TAG_W  = WORD_W - IDX_W;

    logic              valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0]  tag_q    [BTB_ENTRIES];
    logic [ADDR_W-1:0] target_q [BTB_ENTRIES];
    logic [1:0]        ctr_q    [BTB_ENTRIES];

    logic [IDX_W-1:0] w_lkp_idx;
    logic [TAG_W-1:0] w_lkp_tag;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_match;

    assign w_lkp_idx = lkp_word_i[IDX_W-1:0];
    assign w_lkp_tag = lkp_word_i[WORD_W-1:IDX_W];
    assign w_upd_idx = upd_word_i[IDX_W-1:0];
    assign w_upd_tag = upd_word_i[WORD_W-1:IDX_W];

    // Lookup reads the registered arrays, so a same-cycle update is invisible.
    always_comb begin
        lkp_hit_o    = valid_q[w_lkp_idx] && (tag_q[w_lkp_idx] == w_lkp_tag)
                       && ctr_q[w_lkp_idx][1];
        lkp_target_o = target_q[w_lkp_idx];
        w_upd_match  = valid_q[w_upd_idx] && (tag_q[w_upd_idx] == w_upd_tag);
    end

    // Training: counter step on a tag match, allocate only on a taken miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= FALSE;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WEAK_NT;
            end
        end else if (en_i && upd_sig_i) begin
            if (w_upd_match) begin
                ctr_q[w_upd_idx] <= ctr_next(ctr_q[w_upd_idx], upd_taken_i);
                if (upd_taken_i) begin
                    target_q[w_upd_idx] <= upd_target_i;
                end
            end else if (upd_taken_i) begin
                valid_q[w_upd_idx]  <= TRUE;
                tag_q[w_upd_idx]    <= w_upd_tag;
                target_q[w_upd_idx] <= upd_target_i;
                ctr_q[w_upd_idx]    <= CTR_WEAK_T;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_gen
//  Description : Fetch-stage program-counter generator. Offers one request
//                per cycle to the i-cache, predicts the next PC through the
//                BTB and takes absolute redirects from the ROB.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                BTB_ENTRIES = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    pc_gen_if.master  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic              w_hit;
    logic [ADDR_W-1:0] w_btb_target;
    logic [ADDR_W-1:0] w_pred_target;
    logic              w_valid;
    logic              w_unused_low_bits;

    // The BTB and redirect paths only ever consume word addresses.
    assign w_unused_low_bits = ^{bus.flush_pc_in[1:0], bus.btb_upd_pc_in[1:0]};

    pc_gen_btb #(
        .ADDR_W      (ADDR_W),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .en_i         (bus.rdy),
        .lkp_word_i   (pc_q[ADDR_W-1:2]),
        .lkp_hit_o    (w_hit),
        .lkp_target_o (w_btb_target),
        .upd_sig_i    (bus.btb_upd_sig_in),
        .upd_word_i   (bus.btb_upd_pc_in[ADDR_W-1:2]),
        .upd_target_i (bus.btb_upd_target_in),
        .upd_taken_i  (bus.btb_upd_taken_in)
    );

    // Prediction and request qualification, all combinational from the PC.
    always_comb begin
        w_pred_target = w_hit ? w_btb_target : (pc_q + ADDR_W'(4));
        w_valid       = (state_q == ST_FETCH) && bus.rdy && !bus.stall_in
                        && !bus.flush_sig_in;
    end

    assign bus.fetch_valid_out       = w_valid;
    assign bus.fetch_pc_out          = pc_q;
    assign bus.fetch_pred_taken_out  = w_hit;
    assign bus.fetch_pred_target_out = w_pred_target;

    // Next state / next PC: flush beats everything, rdy=0 freezes all.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (bus.rdy) begin
            if (bus.flush_sig_in) begin
                state_d = ST_BUBBLE;
                pc_d    = {bus.flush_pc_in[ADDR_W-1:2], 2'b00};
            end else begin
                case (state_q)
                    ST_IDLE:   state_d = ST_FETCH;
                    ST_FETCH: begin
                        if (w_valid && bus.fetch_ready_in) begin
                            pc_d = w_pred_target;
                        end
                    end
                    ST_BUBBLE: state_d = ST_FETCH;
                    default:   state_d = ST_IDLE;
                endcase
            end
        end
    end

    // State and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_gen
//  Description : Self-checking bench for pc_gen: directed vector table for
//                the fetch/flush/freeze flow plus hand sequences for BTB
//                training, address wrap and mid-run reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    pc_gen_if #(.ADDR_W(ADDR_W)) bus ();

    pc_gen #(
        .ADDR_W      (ADDR_W),
        .RESET_PC    (RST_PC),
        .BTB_ENTRIES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        stall;
        logic        ready;
        logic        flush;
        logic [31:0] flush_pc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_taken;
        logic [31:0] exp_target;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic s, input logic rd,
                          input logic f, input logic [31:0] fpc);
        bus.rdy            = r;
        bus.stall_in       = s;
        bus.fetch_ready_in = rd;
        bus.flush_sig_in   = f;
        bus.flush_pc_in    = fpc;
    endtask

    task automatic set_upd(input logic u, input logic [31:0] upc,
                           input logic [31:0] tgt, input logic tk);
        bus.btb_upd_sig_in    = u;
        bus.btb_upd_pc_in     = upc;
        bus.btb_upd_target_in = tgt;
        bus.btb_upd_taken_in  = tk;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic tk, input logic [31:0] tgt);
        check({tag, "_valid"},  32'(bus.fetch_valid_out),      32'(v));
        check({tag, "_pc"},     bus.fetch_pc_out,              pc);
        check({tag, "_taken"},  32'(bus.fetch_pred_taken_out), 32'(tk));
        check({tag, "_target"}, bus.fetch_pred_target_out,     tgt);
    endtask

    initial begin
        //          rdy stl rdy flu fpc            valid pc            tk  target
        vecs[0]  = '{1, 0, 1, 0, 32'h0,          0, 32'h100,       0, 32'h104};
        vecs[1]  = '{1, 0, 1, 0, 32'h0,          1, 32'h100,       0, 32'h104};
        vecs[2]  = '{1, 0, 0, 0, 32'h0,          1, 32'h104,       0, 32'h108};
        vecs[3]  = '{1, 0, 0, 0, 32'h0,          1, 32'h104,       0, 32'h108};
        vecs[4]  = '{1, 0, 0, 0, 32'h0,          1, 32'h104,       0, 32'h108};
        vecs[5]  = '{1, 0, 1, 0, 32'h0,          1, 32'h104,       0, 32'h108};
        vecs[6]  = '{1, 1, 1, 0, 32'h0,          0, 32'h108,       0, 32'h10C};
        vecs[7]  = '{1, 0, 1, 0, 32'h0,          1, 32'h108,       0, 32'h10C};
        vecs[8]  = '{1, 0, 1, 1, 32'h2003,       0, 32'h10C,       0, 32'h110};
        vecs[9]  = '{1, 0, 1, 0, 32'h0,          0, 32'h2000,      0, 32'h2004};
        vecs[10] = '{1, 0, 1, 0, 32'h0,          1, 32'h2000,      0, 32'h2004};
        vecs[11] = '{0, 0, 1, 1, 32'h3000,       0, 32'h2004,      0, 32'h2008};
        vecs[12] = '{0, 0, 1, 1, 32'h3000,       0, 32'h2004,      0, 32'h2008};
        vecs[13] = '{0, 0, 1, 1, 32'h3000,       0, 32'h2004,      0, 32'h2008};
        vecs[14] = '{0, 0, 1, 1, 32'h3000,       0, 32'h2004,      0, 32'h2008};
        vecs[15] = '{1, 0, 1, 0, 32'h0,          1, 32'h2004,      0, 32'h2008};
        vecs[16] = '{1, 0, 1, 1, 32'h500,        0, 32'h2008,      0, 32'h200C};
        vecs[17] = '{1, 0, 1, 1, 32'h600,        0, 32'h500,       0, 32'h504};
        vecs[18] = '{1, 0, 1, 0, 32'h0,          0, 32'h600,       0, 32'h604};
        vecs[19] = '{1, 0, 0, 0, 32'h0,          1, 32'h600,       0, 32'h604};

        rst = 1'b1;
        set_in(0, 0, 0, 0, 32'h0);
        set_upd(0, 32'h0, 32'h0, 0);
        #12;
        chk_out("reset", 0, RST_PC, 0, RST_PC + 32'd4);
        rst = 1'b0;

        // Table: fetch flow, backpressure, stall, flush, rdy freeze.
        for (int i = 0; i < 20; i++) begin
            set_in(vecs[i].rdy, vecs[i].stall, vecs[i].ready, vecs[i].flush, vecs[i].flush_pc);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                    vecs[i].exp_taken, vecs[i].exp_target);
            tick();
        end

        // BTB training: two taken updates at 0x40 -> strongly taken.
        set_in(1, 0, 0, 0, 32'h0);
        set_upd(1, 32'h40, 32'h80, 1);
        #1;
        chk_out("trainA", 1, 32'h600, 0, 32'h604);
        tick();
        tick();
        set_upd(0, 32'h0, 32'h0, 0);
        set_in(1, 0, 0, 1, 32'h40);
        tick();
        set_in(1, 0, 0, 0, 32'h0);
        #1;
        chk_out("bubble40", 0, 32'h40, 1, 32'h80);
        tick();
        // Not-taken updates; same-cycle lookup must see the old contents.
        set_upd(1, 32'h40, 32'h0, 0);
        #1;
        chk_out("nt1", 1, 32'h40, 1, 32'h80);
        tick();
        #1;
        chk_out("nt2", 1, 32'h40, 1, 32'h80);
        tick();
        set_upd(0, 32'h0, 32'h0, 0);
        set_in(1, 0, 1, 0, 32'h0);
        #1;
        chk_out("weakNT", 1, 32'h40, 0, 32'h44);
        tick();
        set_in(1, 0, 0, 0, 32'h0);
        #1;
        check("seq44_pc", bus.fetch_pc_out, 32'h44);
        // Taken update on a matching entry rewrites the target.
        set_upd(1, 32'h40, 32'hC0, 1);
        tick();
        set_upd(0, 32'h0, 32'h0, 0);
        set_in(1, 0, 0, 1, 32'h40);
        tick();
        set_in(1, 0, 0, 0, 32'h0);
        #1;
        chk_out("retarget", 0, 32'h40, 1, 32'hC0);
        tick();

        // Address wrap at the top of the space, with low flush bits masked.
        set_in(1, 0, 0, 1, 32'hFFFF_FFFE);
        tick();
        set_in(1, 0, 0, 0, 32'h0);
        tick();
        set_in(1, 0, 1, 0, 32'h0);
        #1;
        chk_out("wrap", 1, 32'hFFFF_FFFC, 0, 32'h0);
        tick();
        set_in(1, 0, 0, 0, 32'h0);
        #1;
        check("wrap_next_pc", bus.fetch_pc_out, 32'h0);

        // Asynchronous reset mid-run, with rdy low, clears PC and BTB.
        set_in(0, 0, 0, 0, 32'h0);
        rst = 1'b1;
        #1;
        chk_out("midreset", 0, RST_PC, 0, RST_PC + 32'd4);
        tick();
        rst = 1'b0;
        set_in(1, 0, 0, 1, 32'h40);
        tick();
        set_in(1, 0, 0, 0, 32'h0);
        #1;
        chk_out("btbcleared", 0, 32'h40, 0, 32'h44);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
